// File: rtl/registrador_nivel.sv
// Bounded 7-bit level register driven by INC/DEC keys with press-and-hold auto-repeat,
// a saturating parallel load, and registered MIN/MAX/STEP flags.
module registrador_nivel #(
    parameter int unsigned MAX_VAL = 100,
    parameter int unsigned MIN_VAL = 5,
    parameter int unsigned RST_VAL = 0,
    parameter int unsigned HOLD    = 8,
    parameter int unsigned REPEAT  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [6:0] data_i,
    output logic [6:0] reg_o,
    output logic       min_o,
    output logic       max_o,
    output logic       step_o
);

    localparam int unsigned W       = 7;
    localparam int unsigned CNT_MAX = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [W-1:0]  MAX_V  = W'(MAX_VAL);
    localparam logic [W-1:0]  MIN_V  = W'(MIN_VAL);
    localparam logic [W-1:0]  RST_V  = W'(RST_VAL);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0] RPT_C  = CW'(REPEAT);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RPT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [1:0]    prev_q;
    logic [W-1:0]  reg_q, reg_d;
    logic          step_q, step_d;
    logic          min_q, min_d;
    logic          max_q, max_d;

    logic [1:0]    pat;
    logic          start;
    logic          held;
    logic          step_req;
    logic          step_up;

    assign pat   = {inc_i, dec_i};
    assign start = (inc_i ^ dec_i) && (pat != prev_q);
    // Hold continues only while the latched key is the sole key pressed.
    assign held  = dir_q ? (pat == 2'b10) : (pat == 2'b01);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            prev_q  <= 2'b00;
            reg_q   <= RST_V;
            step_q  <= 1'b0;
            min_q   <= (RST_V <= MIN_V);
            max_q   <= (RST_V == MAX_V);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            prev_q  <= pat;
            reg_q   <= reg_d;
            step_q  <= step_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    // Key FSM: decides when a step is requested and in which direction.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        step_req = 1'b0;
        step_up  = dir_q;
        if (load_i || (inc_i && dec_i)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            step_req = 1'b1;
            step_up  = inc_i;
            dir_d    = inc_i;
            cnt_d    = ONE_C;
            state_d  = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (!held) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == HOLD_C) begin
                        step_req = 1'b1;
                        cnt_d    = ONE_C;
                        state_d  = S_RPT;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                S_RPT: begin
                    if (!held) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == RPT_C) begin
                        step_req = 1'b1;
                        cnt_d    = ONE_C;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Level datapath: saturating load/step; flags computed from the next value.
    always_comb begin
        reg_d  = reg_q;
        step_d = 1'b0;
        if (load_i) begin
            reg_d = (data_i > MAX_V) ? MAX_V : data_i;
        end else if (step_req) begin
            if (step_up && (reg_q < MAX_V)) begin
                reg_d  = reg_q + W'(1);
                step_d = 1'b1;
            end else if (!step_up && (reg_q != '0)) begin
                reg_d  = reg_q - W'(1);
                step_d = 1'b1;
            end
        end
        min_d = (reg_d <= MIN_V);
        max_d = (reg_d == MAX_V);
    end

    assign reg_o  = reg_q;
    assign min_o  = min_q;
    assign max_o  = max_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_registrador_nivel.sv
// Scoreboard bench for registrador_nivel: the driver queues hand-computed expected
// REG/STEP per cycle; a monitor on the falling edge pops and compares all outputs.
module tb_registrador_nivel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc;
    logic       dec;
    logic       load;
    logic [6:0] data;
    logic [6:0] reg_v;
    logic       min_v;
    logic       max_v;
    logic       step_v;

    always #5 clk = ~clk;

    registrador_nivel dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (inc),
        .dec_i  (dec),
        .load_i (load),
        .data_i (data),
        .reg_o  (reg_v),
        .min_o  (min_v),
        .max_o  (max_v),
        .step_o (step_v)
    );

    typedef struct {
        logic [6:0] r;
        logic       s;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock cycle of stimulus plus the expected outputs after its rising edge.
    task automatic cyc(input logic r_n, input logic i, input logic d, input logic l,
                       input logic [6:0] dt, input logic [6:0] er, input logic es,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r_n; inc = i; dec = d; load = l; data = dt;
        @(posedge clk);
        #1;
        e.r = er; e.s = es; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk({e.tag, ".reg"},  int'(reg_v),  int'(e.r));
                chk({e.tag, ".step"}, int'(step_v), int'(e.s));
                chk({e.tag, ".min"},  int'(min_v),  int'(e.r <= 7'd5));
                chk({e.tag, ".max"},  int'(max_v),  int'(e.r == 7'd100));
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; data = '0;

        // Reset with INC held, then fresh start at first released edge
        cyc(0, 1, 0, 0, 0, 0, 0, "rst0");
        cyc(0, 1, 0, 0, 0, 0, 0, "rst1");
        cyc(1, 1, 0, 0, 0, 1, 1, "rst_start");
        cyc(1, 0, 0, 0, 0, 1, 0, "rst_rel");

        // Reset mid-hold, then six single presses
        cyc(1, 1, 0, 0, 0, 2, 1, "pre_hold");
        cyc(0, 1, 0, 0, 0, 0, 0, "rst_midhold");
        cyc(1, 0, 0, 0, 0, 0, 0, "idle0");
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 1, 0, 0, 0, 7'(i), 1, $sformatf("press%0d", i));
            cyc(1, 0, 0, 0, 0, 7'(i), 0, $sformatf("gap%0d", i));
        end

        // Hold INC for 20 cycles from 10: steps at edges 0, 8, 12, 16
        cyc(1, 0, 0, 1, 7'd10, 10, 0, "load10");
        cyc(1, 0, 0, 0, 0, 10, 0, "idle10");
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 0, 0,
                7'(10 + 1 + int'(i >= 8) + int'(i >= 12) + int'(i >= 16)),
                (i == 0) || (i == 8) || (i == 12) || (i == 16),
                $sformatf("hold_inc%0d", i));
        end
        cyc(1, 0, 0, 0, 0, 14, 0, "hold_inc_rel");

        // Load above max saturates; INC at max does not step; DEC steps down
        cyc(1, 0, 0, 1, 7'd120, 100, 0, "load120");
        cyc(1, 0, 0, 0, 0, 100, 0, "idle100");
        cyc(1, 1, 0, 0, 0, 100, 0, "inc_at_max");
        cyc(1, 0, 0, 0, 0, 100, 0, "idle100b");
        cyc(1, 0, 1, 0, 0, 99, 1, "dec_from_max");
        cyc(1, 0, 0, 0, 0, 99, 0, "idle99");

        // Hold DEC for 20 cycles from 2: 1 at edge 0, 0 at edge 8, then held
        cyc(1, 0, 0, 1, 7'd2, 2, 0, "load2");
        cyc(1, 0, 0, 0, 0, 2, 0, "idle2");
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, 0, 0, (i >= 8) ? 7'd0 : 7'd1, (i == 0) || (i == 8),
                $sformatf("hold_dec%0d", i));
        end
        cyc(1, 0, 0, 0, 0, 0, 0, "hold_dec_rel");

        // Both keys, INC released (DEC start), load during hold blocks further steps
        cyc(1, 0, 0, 1, 7'd50, 50, 0, "load50");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 50, 0, $sformatf("both%0d", i));
        cyc(1, 0, 1, 0, 0, 49, 1, "both_to_dec");
        cyc(1, 0, 1, 0, 0, 49, 0, "dec_held");
        cyc(1, 0, 1, 1, 7'd40, 40, 0, "load40_hold");
        for (int i = 0; i < 12; i++) cyc(1, 0, 1, 0, 0, 40, 0, $sformatf("after_load%0d", i));
        cyc(1, 0, 0, 0, 0, 40, 0, "rel40");
        cyc(1, 0, 1, 0, 0, 39, 1, "repress_dec");
        cyc(1, 0, 0, 0, 0, 39, 0, "rel39");

        // Direction change in one cycle starts the new direction
        cyc(1, 0, 0, 1, 7'd20, 20, 0, "load20");
        cyc(1, 1, 0, 0, 0, 21, 1, "inc_then");
        cyc(1, 0, 1, 0, 0, 20, 1, "swap_to_dec");
        cyc(1, 0, 0, 0, 0, 20, 0, "rel20");

        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/registrador_nivel.md
# registrador_nivel

Bounded 7-bit level register with press-and-hold stepping. It is the write side of the level-register interface: it produces and updates `REG[6:0]`, which the minimum-value detector and the rest of the datapath read. Increment and decrement requests come from synchronous key lines, with auto-repeat while a key is held. A parallel load sets the register directly. Saturation and limit flags are generated locally.

## Interface
- `MAX_VAL`, 100: upper saturation value (≤127).
- `MIN_VAL`, 5: `MIN` asserts while `REG` ≤ `MIN_VAL`.
- `RST_VAL`, 0: value of `REG` after reset (≤`MAX_VAL`).
- `HOLD`, 8: cycles from the first step to the first auto-repeat step (≥2).
- `REPEAT`, 4: cycles between auto-repeat steps (≥1).
- `CLK` in 1: the only clock; rising-edge.
- `RST` in 1: reset, synchronous and active-low.
- `INC` in 1: increment key, already synchronous to `CLK`, level.
- `DEC` in 1: decrement key, already synchronous to `CLK`, level.
- `LOAD` in 1: parallel load strobe.
- `DATA` in 7: load value.
- `REG` out 7: current level, registered.
- `MIN` out 1: `REG` ≤ `MIN_VAL`, derived from `REG`, zero added latency.
- `MAX` out 1: `REG` == `MAX_VAL`.
- `STEP` out 1: one-cycle pulse, registered, high in the cycle after any edge where `REG` changed by ±1.

## Operation
- **Key pattern:** `P` = {`INC`,`DEC`}, sampled each edge. `PREV` holds the previous sample.
- **Start condition:** exactly one key is high, and `P` ≠ `PREV`.
- **Priority at each edge:**
  1. `RST`=0
  2. `LOAD`
  3. both keys high
  4. start condition
  5. FSM repeat
- **Load:**
  - `REG` ← min(`DATA`, `MAX_VAL`).
  - FSM → IDLE.
  - `STEP`=0.
  - `PREV` is still updated, so a key held across a load produces no new start.
- **Both keys high:** no step; FSM → IDLE.
- **FSM states:** IDLE, WAIT, RPT. A cycle counter `CNT` covers up to max(`HOLD`,`REPEAT`).
  - **Any state, start condition:**
    - Apply one step in the pressed direction.
    - Latch the direction.
    - `CNT` ← 1.
    - → WAIT.
  - **WAIT, latched key still the only key high:**
    - `CNT`++.
    - When `CNT` reaches `HOLD`: step, `CNT` ← 1, → RPT.
  - **RPT, latched key still the only key high:**
    - `CNT`++.
    - When `CNT` reaches `REPEAT`: step, `CNT` ← 1.
  - **WAIT/RPT, pattern no longer "latched key only" and no start:** → IDLE, no step.
- **Step arithmetic:**
  - Increment when `REG` < `MAX_VAL`; otherwise `REG` is held.
  - Decrement when `REG` > 0; otherwise `REG` is held.
  - A saturated step leaves `REG` unchanged, `STEP` stays 0, and the FSM keeps timing.
  - There is no wrap-around.
- **Reset (`RST`=0 at an edge):**
  - `REG`=`RST_VAL`, `STEP`=0.
  - FSM=IDLE, `CNT`=0, `PREV`=00.
  - `MIN`/`MAX` follow `REG`. With defaults: `MIN`=1, `MAX`=0.
  - Reset mid-hold aborts the hold.
  - A key still high at the first edge with `RST`=1 is a fresh start, because `PREV`=00.

## Timing
- **Step latency:** `REG` updates at the edge that samples the start. `STEP` is high for the following cycle.
- **Auto-repeat schedule:** with the start sampled at edge k and the key held, steps occur at edges k, k+`HOLD`, k+`HOLD`+`REPEAT`, k+`HOLD`+2·`REPEAT`, …
- **Release:** if the key is released before edge k+`HOLD`, exactly one step occurs.
- **Load latency:** `LOAD` takes effect at the sampling edge; `REG` is valid one cycle later.
- **Flag timing:** `MIN`/`MAX` change in the same cycle as `REG`.
- **Simultaneous direction change:** `INC`↓ together with `DEC`↑ in one cycle is a start for `DEC`.

## Test plan
- **Reset:** `RST`=0 for 2 edges with `INC`=1 → `REG`=0, `MIN`=1, `MAX`=0, `STEP`=0. At the first `RST`=1 edge with `INC` still high → `REG`=1, `STEP` pulse.
- **Single presses:** six 1-cycle `INC` pulses separated by idle cycles, from 0 → `REG` 1..6, six `STEP` pulses, `MIN` falls when `REG` goes 5→6.
- **Hold increment:** hold `INC` 20 cycles from `REG`=10 (defaults) → steps at edges 0, 8, 12, 16, final `REG`=14, four `STEP` pulses.
- **Load and upper saturation:** `LOAD` with `DATA`=120 → `REG`=100, `MAX`=1. Then an `INC` press → `REG`=100, `STEP`=0. Then a `DEC` press → `REG`=99, `MAX`=0.
- **Lower saturation:** hold `DEC` 20 cycles from `REG`=2 → `REG`=1 at edge 0, `REG`=0 at edge 8, stays 0, two `STEP` pulses.
- **Both keys, then load during hold:**
  - `INC`=`DEC`=1 for 3 cycles → no step.
  - `INC` released with `DEC` held → one decrement at that edge.
  - `LOAD` with `DATA`=40 during the hold → `REG`=40, and no further steps until `DEC` is released and pressed again.
